// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: computes a - b one bit per clock, LSB first,
// using a single borrow flop and a start/ready/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] pd;
  logic             bflop;
  logic [CW-1:0]    cnt;

  logic             ai;
  logic             bi;
  logic             d;
  logic             bout;
  logic             last_bit;
  logic [WIDTH-1:0] pd_next;

  // One full-subtractor cell; pd_next already contains the bit being produced this cycle.
  always_comb begin
    ai       = a_sr[0];
    bi       = b_sr[0];
    d        = ai ^ bi ^ bflop;
    bout     = (~ai & bi) | (~(ai ^ bi) & bflop);
    pd_next  = {d, pd[WIDTH-1:1]};
    last_bit = (cnt == LAST);
  end

  assign ready = (state == IDLE);
  assign busy  = (state == SHIFT);
  assign done  = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      pd    <= '0;
      bflop <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            pd    <= '0;
            bflop <= 1'b0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          pd    <= pd_next;
          bflop <= bout;
          if (last_bit) begin
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Result registers update only on the final bit so partial words never reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
    end else if (state == SHIFT && last_bit) begin
      diff     <= pd_next;
      borrow   <= bout;
      overflow <= (ai != bi) && (d != ai);
    end
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor computing `a - b` one bit per clock, LSB first, with a single borrow flip-flop. It is the subtractive counterpart of the team's adder cells and sits in the arithmetic library next to them. Its purpose is area-cheap subtraction where latency is not critical. A start/ready/done handshake lets a controller or a self-checking bench drive operations back to back.

## Interface
- `WIDTH`, default 8, operand and result width in bits; legal range is `WIDTH >= 2`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request; sampled only while `ready`=1.
- `a`  in  WIDTH  minuend; captured on the accepting edge.
- `b`  in  WIDTH  subtrahend; captured on the accepting edge.
- `ready`  out  1  high in IDLE; the block accepts `start`.
- `busy`  out  1  high in SHIFT.
- `done`  out  1  one-cycle pulse; the result registers are valid.
- `diff`  out  WIDTH  `(a - b) mod 2^WIDTH`.
- `borrow`  out  1  unsigned borrow, i.e. a < b.
- `overflow`  out  1  signed overflow of `a - b`.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE.
  - `ready` = (state==IDLE).
  - `busy` = (state==SHIFT).
  - `done` = (state==DONE).
- **IDLE**
  - If `start`=1 on an edge:
    - load `a` and `b` into internal shift registers;
    - clear the borrow flop and the bit counter;
    - go to SHIFT.
  - Otherwise stay in IDLE.
- **SHIFT**, one bit per edge. With operand bits `ai`, `bi` at the shift-register LSBs and borrow-in `bin`:
  - `d = ai ^ bi ^ bin`
  - `bout = (~ai & bi) | (~(ai ^ bi) & bin)`
  - Shift `d` into the MSB of the partial-difference register.
  - Shift both operand registers right by one.
  - Borrow flop <= `bout`; counter++.
- On the edge that processes bit WIDTH-1, all of the following happen together:
  - `diff` <= the complete partial-difference word, including this bit;
  - `borrow` <= `bout`;
  - `overflow` <= `(a_msb != b_msb) && (d != a_msb)`, where `a_msb` = `ai` and `b_msb` = `bi` of that step;
  - state -> DONE.
- **DONE**: unconditionally go to IDLE on the next edge.
- `diff`, `borrow` and `overflow` are separate output registers.
  - They change only on the final SHIFT edge.
  - They hold their value until the next operation completes. Partial results are never visible.
- `start` during SHIFT or DONE is ignored and is not queued.
- Changes on `a`/`b` after the accepting edge have no effect.
- The counter is `$clog2(WIDTH)` bits wide and never wraps within one operation.

## Timing
- Reset (`rst_n`=0, asynchronous, no clock needed) drives:
  - state IDLE, so `ready`=1, `busy`=0, `done`=0;
  - `diff`=0, `borrow`=0, `overflow`=0;
  - shift registers, counter and borrow flop to 0.
- Reset during SHIFT or DONE aborts the operation. The outputs take the reset values above, and the aborted result is lost.
- Deassertion of reset is synchronous to `clk` at the board level. The first `start` is accepted on the first rising edge after `rst_n`=1.
- Latency, with edge 0 as the edge that samples `start`=1 in IDLE:
  - edges 1..WIDTH process bits 0..WIDTH-1;
  - `done`, `diff`, `borrow` and `overflow` are valid after edge WIDTH;
  - `done` drops and `ready` rises after edge WIDTH+1.
- Throughput is one operation per WIDTH+2 cycles. With `start` held high, the next operation is accepted on edge WIDTH+2.
- `done` is exactly one cycle wide and never coincides with `ready`.

## Test plan
- **Basic subtraction.** WIDTH=8, a=0x35, b=0x12, single `start` pulse. Required response:
  - `busy`=1 for exactly 8 cycles;
  - `done` after edge 8 with `diff`=0x23, `borrow`=0, `overflow`=0;
  - `ready`=1 after edge 9.
- **Borrow and signed overflow.** Three operations in sequence:
  - 0x00-0x01 -> `diff`=0xFF, `borrow`=1, `overflow`=0.
  - 0x80-0x01 -> `diff`=0x7F, `borrow`=0, `overflow`=1.
  - 0x7F-0xFF -> `diff`=0x80, `borrow`=1, `overflow`=1.
- **Equal operands and no-op.**
  - 0xA5-0xA5 -> `diff`=0x00, `borrow`=0, `overflow`=0.
  - 0x00-0x00 -> `diff`=0x00, `borrow`=0, `overflow`=0.
- **Ignored start and input changes.**
  - Start 0x10-0x01.
  - Pulse `start` again with a=0xFF, b=0x00 at edges 3 and 8, and change `a`/`b` every cycle.
  - Required: a single `done` with `diff`=0x0F, and no second operation begins.
- **Reset mid-operation.**
  - Start 0x35-0x12 and assert `rst_n`=0 between edges 4 and 5. Required: all outputs go to reset values immediately, and no `done` appears.
  - After release, 0x09-0x03 -> `diff`=0x06 at the expected latency.
- **Back-to-back operation.**
  - Hold `start`=1 and change operands every cycle across 3 operations, using random values plus all-ones and all-zeros.
  - Required:
    - operations are accepted on edges 0, 10 and 20;
    - each result matches a reference model applied to the operands present at its accepting edge;
    - outputs hold between `done` pulses.
